// File: rtl/nibble_arbiter.sv
// nibble_arbiter: two-requester round-robin arbiter that serializes one byte
// per grant into a nibble-wide FIFO write port (low nibble, then high nibble).
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   req0/req1       requester wants to write one byte
//   data0/data1     requester nibble (low first, then high)
//   grant0/grant1   requester owns the FIFO write port this cycle
//   fifo_din        nibble to FIFO Data_In
//   fifo_wr         FIFO write strobe (follows fifo_rdy while busy)
//   fifo_rdy        FIFO accepts a nibble this cycle
//   busy            byte transfer in progress (LOW or HIGH)
//   count0/count1   completed-byte counters, wrap modulo 2^CNT_W
//
// Build option: define NIBBLE_ARB_STATS_EN to build the byte counters;
// otherwise count0/count1 are tied to zero.
module nibble_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [3:0]       data0,
  input  logic [3:0]       data1,
  output logic             grant0,
  output logic             grant1,
  output logic [3:0]       fifo_din,
  output logic             fifo_wr,
  input  logic             fifo_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;   // current byte owner
  logic   last_q,  last_d;    // last requester that completed a byte
  logic   active;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  owner_d = ~last_q;
        else if (req0)     owner_d = 1'b0;
        else if (req1)     owner_d = 1'b1;
        if (req0 || req1)  state_d = LOW;
      end
      LOW: begin
        if (fifo_rdy) state_d = HIGH;
      end
      HIGH: begin
        if (fifo_rdy) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // requester 0 wins the first tie
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs are gated by rst so nothing is written while reset is asserted,
  // including the cycle in which a partial byte is abandoned.
  assign active   = rst && (state_q != IDLE);
  assign busy     = active;
  assign grant0   = active && !owner_q;
  assign grant1   = active &&  owner_q;
  assign fifo_wr  = active && fifo_rdy;
  assign fifo_din = active ? (owner_q ? data1 : data0) : 4'h0;

`ifdef NIBBLE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             done;

  assign done = (state_q == HIGH) && fifo_rdy;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (done && !owner_q) cnt0_d = cnt0_q + 1'b1;
    if (done &&  owner_q) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign count0 = rst ? cnt0_q : '0;
  assign count1 = rst ? cnt1_q : '0;
`else
  assign count0 = '0;
  assign count1 = '0;
`endif

endmodule

// File: tb/tb_nibble_arbiter.sv
module tb_nibble_arbiter;
  localparam int CNT_W = 2;
`ifdef NIBBLE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, req0, req1, fifo_rdy;
  logic [3:0] data0, data1, fifo_din;
  logic grant0, grant1, fifo_wr, busy;
  logic [CNT_W-1:0] count0, count1;
  logic [CNT_W-1:0] exp_c0, exp_c1;
  int passes = 0;
  int total  = 0;

  nibble_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .grant0(grant0), .grant1(grant1),
    .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_rdy(fifo_rdy),
    .busy(busy), .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance one clock; inputs changed afterwards settle 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_c0"}, 8'(count0), STATS ? 8'(exp_c0) : 8'h0);
    check({tag, "_c1"}, 8'(count1), STATS ? 8'(exp_c1) : 8'h0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 8'(busy), 8'h0);
    check({tag, "_wr"},   8'(fifo_wr), 8'h0);
    check({tag, "_g"},    {6'h0, grant1, grant0}, 8'h0);
    check({tag, "_din"},  8'(fifo_din), 8'h0);
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; fifo_rdy = 1'b0;
    data0 = 4'h0; data1 = 4'h0;
    exp_c0 = '0; exp_c1 = '0;

    // reset for two cycles
    tick(); tick();
    check_idle("rst_hold");
    check_counts("rst_hold");
    rst = 1'b1;
    tick();
    check_idle("rst_rel");
    check_counts("rst_rel");

    // single byte from requester 0; req dropped after grant
    req0 = 1'b1; data0 = 4'h5; fifo_rdy = 1'b1;
    settle();
    check_idle("sb_idle");
    tick();
    check("sb_lo_g", {6'h0, grant1, grant0}, 8'h1);
    check("sb_lo_wr", 8'(fifo_wr), 8'h1);
    check("sb_lo_din", 8'(fifo_din), 8'h5);
    check("sb_lo_busy", 8'(busy), 8'h1);
    req0 = 1'b0; data0 = 4'hA;
    tick();
    check("sb_hi_g", {6'h0, grant1, grant0}, 8'h1);
    check("sb_hi_wr", 8'(fifo_wr), 8'h1);
    check("sb_hi_din", 8'(fifo_din), 8'hA);
    tick();
    exp_c0 = exp_c0 + 1'b1;
    check_idle("sb_done");
    check_counts("sb_done");

    // reset so the contention run starts from a tie favouring requester 0
    rst = 1'b0;
    tick();
    exp_c0 = '0; exp_c1 = '0;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 4'h3; data1 = 4'hC;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("ct%0d_idle", i), 8'(busy), 8'h0);
      tick();
      check($sformatf("ct%0d_lo_g", i), {6'h0, grant1, grant0}, (i % 2 == 0) ? 8'h1 : 8'h2);
      check($sformatf("ct%0d_lo_din", i), 8'(fifo_din), (i % 2 == 0) ? 8'h3 : 8'hC);
      tick();
      check($sformatf("ct%0d_hi_g", i), {6'h0, grant1, grant0}, (i % 2 == 0) ? 8'h1 : 8'h2);
      tick();
      if (i % 2 == 0) exp_c0 = exp_c0 + 1'b1;
      else            exp_c1 = exp_c1 + 1'b1;
    end
    check_counts("ct_done");

    // stall in LOW for three cycles
    req1 = 1'b0; data0 = 4'h7; fifo_rdy = 1'b1;
    tick();
    fifo_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("st%0d_wr", i), 8'(fifo_wr), 8'h0);
      check($sformatf("st%0d_g", i), {6'h0, grant1, grant0}, 8'h1);
      check($sformatf("st%0d_busy", i), 8'(busy), 8'h1);
      tick();
    end
    fifo_rdy = 1'b1;
    settle();
    check("st_lo_wr", 8'(fifo_wr), 8'h1);
    check("st_lo_din", 8'(fifo_din), 8'h7);
    tick();
    data0 = 4'h8;
    settle();
    check("st_hi_wr", 8'(fifo_wr), 8'h1);
    check("st_hi_din", 8'(fifo_din), 8'h8);
    req0 = 1'b0;
    tick();
    exp_c0 = exp_c0 + 1'b1;
    check_idle("st_done");
    check_counts("st_done");

    // reset while in HIGH; last served is 0, so only reset makes 0 win next
    req0 = 1'b1; data0 = 4'h1;
    tick();
    tick();
    check("mr_hi_busy", 8'(busy), 8'h1);
    rst = 1'b0; req1 = 1'b1;
    settle();
    check("mr_rst_wr", 8'(fifo_wr), 8'h0);
    check("mr_rst_g", {6'h0, grant1, grant0}, 8'h0);
    tick();
    exp_c0 = '0; exp_c1 = '0;
    rst = 1'b1;
    settle();
    check_idle("mr_idle");
    check_counts("mr_idle");
    tick();
    check("mr_win_g", {6'h0, grant1, grant0}, 8'h1);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    exp_c0 = exp_c0 + 1'b1;
    check_counts("mr_done");

    // five bytes from requester 1: counter wraps modulo 4
    req1 = 1'b1; data1 = 4'h9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wr%0d_g", i), {6'h0, grant1, grant0}, 8'h2);
      tick(); tick();
      exp_c1 = exp_c1 + 1'b1;
    end
    req1 = 1'b0;
    settle();
    check("wr_c1_lit", 8'(count1), STATS ? 8'h1 : 8'h0);
    check_counts("wr_done");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nibble_arbiter.md
NIBBLE_ARBITER -- requirements
Module: nibble_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of per-requester byte counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 req0  input  1  requester 0 wants to write one byte (two nibbles).
REQ-005 req1  input  1  requester 1 wants to write one byte.
REQ-006 data0  input  4  requester 0 nibble; low nibble first, then high nibble.
REQ-007 data1  input  4  requester 1 nibble; same ordering.
REQ-008 grant0  output  1  requester 0 owns the FIFO write port this cycle.
REQ-009 grant1  output  1  requester 1 owns the FIFO write port this cycle.
REQ-010 fifo_din  output  4  nibble driven to the FIFO Data_In.
REQ-011 fifo_wr  output  1  write strobe to the FIFO input_enable.
REQ-012 fifo_rdy  input  1  FIFO input_valid; high means a nibble write is accepted this cycle.
REQ-013 busy  output  1  high while a byte transfer is in progress.
REQ-014 count0  output  CNT_W  bytes completed for requester 0.
REQ-015 count1  output  CNT_W  bytes completed for requester 1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOW, HIGH.
REQ-017 In IDLE with at least one req high, the block SHALL select a winner and move to LOW on the next edge; with no req, it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: when both reqs are high, the requester not served last wins; a single req wins outright.
REQ-019 In LOW and HIGH, grantN SHALL be high for the owner only; both grants SHALL be low in IDLE; grant0 and grant1 SHALL never be high together.
REQ-020 In LOW and HIGH, fifo_din SHALL equal the owner's data combinationally; fifo_wr SHALL equal fifo_rdy; in IDLE, fifo_wr SHALL be 0 and fifo_din SHALL be 4'h0.
REQ-021 In LOW, fifo_rdy high SHALL advance to HIGH; fifo_rdy low SHALL hold LOW (stall, no write).
REQ-022 In HIGH, fifo_rdy high SHALL return to IDLE, record the owner as last-served, and increment the owner's counter; fifo_rdy low SHALL hold HIGH.
REQ-023 A granted requester SHALL hold its data stable while its grant is high and fifo_rdy is low.
REQ-024 Once granted, the byte SHALL complete even if the owner deasserts req; nibbles of different requesters SHALL never interleave.
REQ-025 Minimum byte cost SHALL be 3 cycles (IDLE, LOW, HIGH); back-to-back requesters SHALL alternate.
REQ-026 busy SHALL be high exactly in LOW and HIGH.
REQ-027 Counters SHALL wrap modulo 2^CNT_W without saturation or a flag.

Reset
REQ-028 With rst low at a clock edge: state SHALL become IDLE, last-served SHALL become requester 1 (so requester 0 wins the first tie), and both counters SHALL become 0.
REQ-029 All outputs SHALL be 0 during and immediately after reset.
REQ-030 Reset in LOW or HIGH SHALL abandon the partial byte without a further fifo_wr; the upstream FIFO SHALL be reset together with this block.

Configuration
REQ-031 Macro NIBBLE_ARB_STATS_EN: when defined, count0/count1 SHALL operate per REQ-022/027; when undefined, they SHALL be tied to 0 and no counter registers SHALL be built.

Verification
REQ-032 Reset: rst=0 for 2 cycles, then 1 with no reqs -> grants=0, fifo_wr=0, busy=0, counts=0.
REQ-033 Single byte: req0=1, data0=4'h5 then 4'hA, fifo_rdy=1 -> fifo_wr high for 2 cycles carrying 5 then A; count0=1.
REQ-034 Contention: req0=req1=1 continuously, fifo_rdy=1 -> grant order 0,1,0,1; each byte 3 cycles; after 4 bytes, count0=count1=2.
REQ-035 Stall: in LOW, fifo_rdy=0 for 3 cycles -> state holds, fifo_wr=0; the nibble is written on the cycle fifo_rdy returns to 1.
REQ-036 Mid-op reset: rst=0 while in HIGH -> next cycle IDLE, no fifo_wr; with both reqs then high, requester 0 wins.
REQ-037 Wrap (macro on, CNT_W=2): 5 bytes from req1 -> count1=1.
